// File: rtl/tlight_pkg.sv
// tlight_pkg: shared state/direction types and lamp codes
// for the two-way traffic-light controller.
package tlight_pkg;

  typedef enum logic [2:0] {
    GREEN,
    YELLOW,
    ALL_RED,
    WALK,
    FLASH
  } state_e;

  typedef enum logic {
    NS,
    WE
  } dir_e;

  // lamp order is {red,yellow,green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  function automatic dir_e flip(input dir_e d);
    return (d == NS) ? WE : NS;
  endfunction

endpackage

// File: rtl/tlight_phase_timer.sv
// tlight_phase_timer: phase counter; clr zeroes it, otherwise it
// counts up and saturates at lim. at = (cnt == lim).
module tlight_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt,
  output logic             at
);

  assign at = (cnt == lim);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!at) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlight_ctrl.sv
// tlight_ctrl: demand-actuated NS/WE sequencer with walk phase
// and night flash. Ports: clock, reset_n, ns_car, we_car,
// ped_req, night_mode in; ns, we, walk, ped_ack, phase out.
module tlight_ctrl
  import tlight_pkg::*;
#(
  parameter int GREEN_MIN  = 16,
  parameter int GREEN_MAX  = 48,
  parameter int YELLOW_T   = 4,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 20,
  parameter int FLASH_HALF = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ns_car,
  input  logic       we_car,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_AR   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] L_FL   = CNT_W'(FLASH_HALF - 1);

  state_e           state, state_nx;
  dir_e             dir, dir_nx;
  logic             ped_pend, pend_nx;
  logic             flash, flash_nx;
  logic [CNT_W-1:0] cnt, lim;
  logic             at, clr, enter;
  logic             own, other, opp;
  logic [2:0]       ns_nx, we_nx;
  logic             walk_nx, ack_nx;

  tlight_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .lim     (lim),
    .cnt     (cnt),
    .at      (at)
  );

  assign own   = (dir == NS) ? ns_car : we_car;
  assign other = (dir == NS) ? we_car : ns_car;
  assign opp   = other | ped_pend | night_mode;
  assign phase = state;

  // GREEN's limit doubles as both max-out and the saturation point
  always_comb begin
    lim = L_AR;
    unique case (state)
      GREEN:   lim = L_GMAX;
      YELLOW:  lim = L_YEL;
      ALL_RED: lim = L_AR;
      WALK:    lim = L_WALK;
      FLASH:   lim = L_FL;
      default: lim = L_AR;
    endcase
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    flash_nx = flash;
    unique case (state)
      GREEN: begin
        if (opp && cnt >= L_GMIN && (!own || at))
          state_nx = YELLOW;
      end
      YELLOW: begin
        if (at) begin
          state_nx = ALL_RED;
          dir_nx   = flip(dir);
        end
      end
      ALL_RED: begin
        if (at) begin
          if (night_mode) begin
            state_nx = FLASH;
            flash_nx = 1'b1;
          end else if (ped_pend) begin
            state_nx = WALK;
          end else begin
            state_nx = GREEN;
          end
        end
      end
      WALK: begin
        if (at) state_nx = ALL_RED;
      end
      FLASH: begin
        if (!night_mode) begin
          state_nx = ALL_RED;
          dir_nx   = NS;
        end else if (at) begin
          flash_nx = ~flash;
        end
      end
      default: state_nx = ALL_RED;
    endcase

    enter = (state_nx != state);
    // FLASH reuses the timer as a free-running half-period divider
    clr   = enter | ((state == FLASH) & at);

    pend_nx = ped_pend | (ped_req & (state != FLASH));
    if (enter && (state_nx == WALK || state_nx == FLASH))
      pend_nx = 1'b0;

    ns_nx = RED;
    we_nx = RED;
    unique case (state_nx)
      GREEN: begin
        if (dir_nx == NS) ns_nx = GRN;
        else              we_nx = GRN;
      end
      YELLOW: begin
        if (dir_nx == NS) ns_nx = YEL;
        else              we_nx = YEL;
      end
      FLASH: begin
        ns_nx = flash_nx ? YEL : OFF;
        we_nx = flash_nx ? YEL : OFF;
      end
      default: begin
        ns_nx = RED;
        we_nx = RED;
      end
    endcase

    walk_nx = (state_nx == WALK);
    ack_nx  = enter & (state_nx == WALK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ALL_RED;
      dir      <= NS;
      ped_pend <= 1'b0;
      flash    <= 1'b0;
      ns       <= RED;
      we       <= RED;
      walk     <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      ped_pend <= pend_nx;
      flash    <= flash_nx;
      ns       <= ns_nx;
      we       <= we_nx;
      walk     <= walk_nx;
      ped_ack  <= ack_nx;
    end
  end

endmodule

// File: tb/tb_tlight_ctrl.sv
// tb_tlight_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked against a phase-level model.
module tb_tlight_ctrl;

  localparam int GMIN = 16;
  localparam int GMAX = 48;
  localparam int YT   = 4;
  localparam int ART  = 2;
  localparam int WT   = 20;
  localparam int FH   = 8;

  // model phase codes: 0 green,1 yellow,2 all-red,3 walk,4 flash
  localparam int P_G = 0;
  localparam int P_Y = 1;
  localparam int P_R = 2;
  localparam int P_W = 3;
  localparam int P_F = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       ns_car = 1'b0;
  logic       we_car = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] ns, we, phase;
  logic       walk, ped_ack;

  int tests = 0;
  int fails = 0;
  int acks = 0;

  int m_st = P_R;
  int m_dir = 0;
  int m_el = 0;
  bit m_ped = 1'b0;
  bit m_ack = 1'b0;

  always #5 clock = ~clock;

  tlight_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ns_car     (ns_car),
    .we_car     (we_car),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .ns         (ns),
    .we         (we),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = P_R;
    m_dir = 0;
    m_el  = 0;
    m_ped = 1'b0;
    m_ack = 1'b0;
  endtask

  task automatic model_step();
    int nx;
    bit own, oth, opp, pn;
    own = (m_dir == 0) ? ns_car : we_car;
    oth = (m_dir == 0) ? we_car : ns_car;
    opp = oth | m_ped | night_mode;
    nx  = m_st;
    case (m_st)
      P_G:
        if (m_el >= GMIN - 1 && opp &&
            (!own || m_el >= GMAX - 1))
          nx = P_Y;
      P_Y:
        if (m_el >= YT - 1) begin
          nx = P_R;
          m_dir = 1 - m_dir;
        end
      P_R:
        if (m_el >= ART - 1)
          nx = night_mode ? P_F : (m_ped ? P_W : P_G);
      P_W:
        if (m_el >= WT - 1) nx = P_R;
      default:
        if (!night_mode) begin
          nx = P_R;
          m_dir = 0;
        end
    endcase
    pn = (m_st == P_F) ? m_ped : (m_ped | ped_req);
    if (nx != m_st && (nx == P_W || nx == P_F)) pn = 1'b0;
    m_ack = (nx == P_W && m_st != P_W);
    m_el  = (nx != m_st) ? 0 : m_el + 1;
    m_st  = nx;
    m_ped = pn;
  endtask

  function automatic logic [2:0] exp_lamp(input int appr);
    case (m_st)
      P_G: return (appr == m_dir) ? 3'b001 : 3'b100;
      P_Y: return (appr == m_dir) ? 3'b010 : 3'b100;
      P_F: return ((m_el / FH) % 2 == 0) ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic compare_cycle();
    if (ped_ack === 1'b1) acks++;
    check("ns", 32'(ns), 32'(exp_lamp(0)));
    check("we", 32'(we), 32'(exp_lamp(1)));
    check("walk", 32'(walk), 32'(m_st == P_W));
    check("ped_ack", 32'(ped_ack), 32'(m_ack));
    check("phase", 32'(phase), 32'(m_st));
  endtask

  always @(negedge clock) compare_cycle();

  task automatic run_len(input logic [2:0] en,
                         input logic [2:0] ew,
                         input logic ewk,
                         input int bound,
                         output int n);
    n = 0;
    while (n < bound && ns === en && we === ew &&
           walk === ewk) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset_n    = 1'b0;
    ns_car     = 1'b0;
    we_car     = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, a0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ns", 32'(ns), 32'(3'b100));
    check("rst_we", 32'(we), 32'(3'b100));
    check("rst_walk", 32'(walk), 0);
    check("rst_ack", 32'(ped_ack), 0);
    reset_n = 1'b1;

    // idle: 2 all-red then NS rests in green
    run_len(3'b100, 3'b100, 1'b0, 50, n);
    check("t1_allred", n, 2);
    check("t1_ns_g", 32'(ns), 32'(3'b001));
    run_len(3'b001, 3'b100, 1'b0, 120, n);
    check("t1_rest", n, 120);

    // WE demand at cnt 5: 16 green, 4 yellow, 2 red
    do_reset();
    repeat (7) @(negedge clock);
    we_car = 1'b1;
    run_len(3'b001, 3'b100, 1'b0, 100, n);
    check("t2_green_rem", n, 11);
    run_len(3'b010, 3'b100, 1'b0, 100, n);
    check("t2_yel", n, 4);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t2_red", n, 2);
    check("t2_we_g", 32'(we), 32'(3'b001));

    // both approaches busy: 48-cycle max-out greens
    ns_car = 1'b1;
    run_len(3'b100, 3'b001, 1'b0, 100, n);
    check("t3_we_g", n, 48);
    run_len(3'b100, 3'b010, 1'b0, 100, n);
    check("t3_we_y", n, 4);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t3_red", n, 2);
    run_len(3'b001, 3'b100, 1'b0, 100, n);
    check("t3_ns_g", n, 48);

    // pedestrian pulse at NS green cnt 3
    do_reset();
    repeat (5) @(negedge clock);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    run_len(3'b001, 3'b100, 1'b0, 100, n);
    check("t4_green_rem", n, 12);
    a0 = acks;
    run_len(3'b010, 3'b100, 1'b0, 100, n);
    check("t4_yel", n, 4);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t4_red1", n, 2);
    run_len(3'b100, 3'b100, 1'b1, 100, n);
    check("t4_walk", n, 20);
    check("t4_acks", acks - a0, 1);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t4_red2", n, 2);
    check("t4_we_g", 32'(we), 32'(3'b001));

    // night mode at WE green cnt 3
    repeat (3) @(negedge clock);
    night_mode = 1'b1;
    run_len(3'b100, 3'b001, 1'b0, 100, n);
    check("t5_green_rem", n, 13);
    run_len(3'b100, 3'b010, 1'b0, 100, n);
    check("t5_yel", n, 4);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t5_red", n, 2);
    ped_req = 1'b1;
    run_len(3'b010, 3'b010, 1'b0, 100, n);
    check("t5_fl_on", n, 8);
    ped_req = 1'b0;
    run_len(3'b000, 3'b000, 1'b0, 100, n);
    check("t5_fl_off", n, 8);
    repeat (3) @(negedge clock);
    night_mode = 1'b0;
    @(negedge clock);
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    check("t5_red2", n, 2);
    check("t5_ns_g", 32'(ns), 32'(3'b001));

    // async reset in the middle of yellow
    do_reset();
    we_car = 1'b1;
    run_len(3'b100, 3'b100, 1'b0, 100, n);
    run_len(3'b001, 3'b100, 1'b0, 100, n);
    check("t6_green", n, 16);
    repeat (2) @(negedge clock);
    check("t6_in_yel", 32'(ns), 32'(3'b010));
    #2 reset_n = 1'b0;
    we_car = 1'b0;
    #1;
    check("t6_rst_ns", 32'(ns), 32'(3'b100));
    check("t6_rst_we", 32'(we), 32'(3'b100));
    check("t6_rst_walk", 32'(walk), 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_len(3'b100, 3'b100, 1'b0, 50, n);
    check("t6_allred", n, 2);
    check("t6_ns_g", 32'(ns), 32'(3'b001));

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 19) == 0) ns_car = ~ns_car;
      if ($urandom_range(0, 19) == 0) we_car = ~we_car;
      ped_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 299) == 0)
        night_mode = ~night_mode;
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
